// File: rtl/clock_monitor.sv
// Measures period, high time and rising-edge count of an asynchronous signal in clk cycles,
// flags a stalled source. Optional min/max period tracking under CLOCK_MONITOR_MINMAX_EN.
module clock_monitor #(
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
`ifdef CLOCK_MONITOR_MINMAX_EN
  input  logic             minmax_clr,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max,
`endif
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             stalled,
  output logic [15:0]      edge_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_STALLED
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STALL_LIMIT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_hcnt;
  logic [CNT_W-1:0]       r_period;
  logic [CNT_W-1:0]       r_high_time;
  logic                   r_meas_valid;
  logic [15:0]            r_edge_count;
  state_t                 r_state;
  state_t                 w_state_nxt;

  logic w_s;
  logic w_rise;
  logic w_stall_hit;
  logic w_capture;
  logic w_stalled;

  // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_s_d  <= w_s;
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;

  // Both counters restart at 1 so the rise cycle itself is part of the new interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_hcnt <= '0;
    end else if (w_rise) begin
      r_cnt  <= CNT_W'(1);
      r_hcnt <= CNT_W'(1);
    end else begin
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      if (w_s && (r_hcnt != CNT_MAX)) r_hcnt <= r_hcnt + 1'b1;
    end
  end

  // A rise in the threshold cycle wins, so the stall condition excludes it.
  assign w_stall_hit = !w_rise && (r_cnt == LIMIT_M1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: default assignment first so no path through the case leaves a latch behind.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rise)           w_state_nxt = ST_MEASURE;
        else if (w_stall_hit) w_state_nxt = ST_STALLED;
      end
      ST_MEASURE: begin
        if (w_stall_hit) w_state_nxt = ST_STALLED;
      end
      ST_STALLED: begin
        if (w_rise) w_state_nxt = ST_MEASURE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_capture = 1'b0;
    w_stalled = 1'b0;
    unique case (r_state)
      ST_MEASURE: w_capture = w_rise;
      ST_STALLED: w_stalled = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_period     <= '0;
      r_high_time  <= '0;
      r_meas_valid <= 1'b0;
      r_edge_count <= '0;
    end else begin
      r_meas_valid <= w_capture;
      if (w_capture) begin
        r_period    <= r_cnt;
        r_high_time <= r_hcnt;
      end
      if (w_rise) r_edge_count <= r_edge_count + 16'd1;
    end
  end

  assign period     = r_period;
  assign high_time  = r_high_time;
  assign meas_valid = r_meas_valid;
  assign stalled    = w_stalled;
  assign edge_count = r_edge_count;

`ifdef CLOCK_MONITOR_MINMAX_EN
  logic [CNT_W-1:0] r_period_min;
  logic [CNT_W-1:0] r_period_max;

  // Extremes update on the same edge as period, so they move together with meas_valid.
  always_ff @(posedge clk) begin
    if (rst || minmax_clr) begin
      r_period_min <= CNT_MAX;
      r_period_max <= '0;
    end else if (w_capture) begin
      if (r_cnt < r_period_min) r_period_min <= r_cnt;
      if (r_cnt > r_period_max) r_period_max <= r_cnt;
    end
  end

  assign period_min = r_period_min;
  assign period_max = r_period_max;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// Self-checking bench for clock_monitor: directed and random waveforms on sig_in compared
// against an interval-level reference model. Covers CLOCK_MONITOR_MINMAX_EN when defined.
module tb_clock_monitor;

  localparam int CNT_W = 16;
  localparam int L     = 50;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             stalled;
  logic [15:0]      edge_count;
`ifdef CLOCK_MONITOR_MINMAX_EN
  logic             minmax_clr = 1'b0;
  logic [CNT_W-1:0] period_min;
  logic [CNT_W-1:0] period_max;
`endif

  clock_monitor #(.CNT_W(CNT_W), .STALL_LIMIT(L), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
`ifdef CLOCK_MONITOR_MINMAX_EN
    .minmax_clr (minmax_clr),
    .period_min (period_min),
    .period_max (period_max),
`endif
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .stalled    (stalled),
    .edge_count (edge_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int p;
    int h;
  } meas_t;

  // Monitor: logs every valid measurement, back-to-back valids and stall onsets.
  meas_t obs_q[$];
  logic  prev_mv = 1'b0;
  logic  prev_st = 1'b0;
  int    consec = 0;
  int    stall_n = 0;
  int    stall_cyc = -1;

  always @(negedge clk) begin
    if (meas_valid === 1'b1) obs_q.push_back('{p: int'(period), h: int'(high_time)});
    if (meas_valid === 1'b1 && prev_mv === 1'b1) consec <= consec + 1;
    if (stalled === 1'b1 && prev_st !== 1'b1) begin
      stall_n   <= stall_n + 1;
      stall_cyc <= cyc;
    end
    prev_mv <= meas_valid;
    prev_st <= stalled;
  end

  // Reference model: works on the sig_in waveform itself; an interval between two rises of
  // length N is reported iff an earlier edge armed the measurement and N < L.
  meas_t exp_q[$];
  int    obs_rd  = 0;
  bit    m_prev  = 1'b0;
  bit    m_armed = 1'b0;
  int    m_len   = 0;
  int    m_high  = 0;
  int    m_edges = 0;
  int    m_min   = 'hFFFF;
  int    m_max   = 0;
  int    rise_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input bit clr);
    @(posedge clk);
    #1;
    sig_in = v;
`ifdef CLOCK_MONITOR_MINMAX_EN
    minmax_clr = clr;
    if (clr) begin
      m_min = 'hFFFF;
      m_max = 0;
    end
`endif
    if (v && !m_prev) begin
      m_edges  = (m_edges + 1) & 'hFFFF;
      rise_cyc = cyc;
      if (m_armed && m_len < L) begin
        exp_q.push_back('{p: m_len, h: m_high});
        if (m_len < m_min) m_min = m_len;
        if (m_len > m_max) m_max = m_len;
      end
      m_armed = 1'b1;
      m_len   = 0;
      m_high  = 0;
    end
    m_len++;
    if (v) m_high++;
    m_prev = v;
  endtask

  task automatic wave(input int h, input int l);
    repeat (h) step(1'b1, 1'b0);
    repeat (l) step(1'b0, 1'b0);
  endtask

  task automatic compare(input string tag);
    int n_obs;
    n_obs = obs_q.size() - obs_rd;
    chk({tag, ".n_valid"}, n_obs, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n_obs; i++) begin
      chk({tag, ".period"}, obs_q[obs_rd + i].p, exp_q[i].p);
      chk({tag, ".high_time"}, obs_q[obs_rd + i].h, exp_q[i].h);
    end
    chk({tag, ".edge_count"}, edge_count, m_edges);
`ifdef CLOCK_MONITOR_MINMAX_EN
    chk({tag, ".period_min"}, period_min, m_min);
    chk({tag, ".period_max"}, period_max, m_max);
`endif
    obs_rd = obs_q.size();
    exp_q.delete();
  endtask

  // Hold the current level long enough for the last rise to reach the outputs, then compare.
  task automatic flush(input string tag);
    repeat (4) step(m_prev, 1'b0);
    compare(tag);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst    = 1'b1;
    sig_in = 1'b0;
`ifdef CLOCK_MONITOR_MINMAX_EN
    minmax_clr = 1'b0;
`endif
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_prev  = 1'b0;
    m_armed = 1'b0;
    m_len   = 0;
    m_high  = 0;
    m_edges = 0;
    m_min   = 'hFFFF;
    m_max   = 0;
    exp_q.delete();
    obs_rd  = obs_q.size();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".period"}, period, 0);
    chk({tag, ".high_time"}, high_time, 0);
    chk({tag, ".meas_valid"}, meas_valid, 0);
    chk({tag, ".stalled"}, stalled, 0);
    chk({tag, ".edge_count"}, edge_count, 0);
`ifdef CLOCK_MONITOR_MINMAX_EN
    chk({tag, ".period_min"}, period_min, 'hFFFF);
    chk({tag, ".period_max"}, period_max, 0);
`endif
  endtask

  initial begin
    int n0;
    int r0;

    repeat (2) @(posedge clk);
    do_reset();
    check_reset_state("reset");

    // 10 high / 10 low square wave, five periods.
    repeat (5) wave(10, 10);
    flush("square");

    // Duty change to 3 high / 17 low.
    wave(3, 17);
    wave(3, 17);
    flush("duty");

    // Interval of L-1 must measure; interval of exactly L must stall and be discarded.
    n0 = stall_n;
    wave(10, 39);
    wave(10, 40);
    r0 = rise_cyc;
    wave(5, 5);
    wave(5, 5);
    flush("limit");
    chk("limit.stall_events", stall_n - n0, 1);
    chk("limit.stall_cycle", stall_cyc, r0 + SYNC + L);

    // Long stall, recovery edge without valid, then a correct period.
    n0 = stall_n;
    wave(5, 60);
    r0 = rise_cyc;
    chk("stall.level", stalled, 1);
    chk("stall.cycle", stall_cyc, r0 + SYNC + L);
    chk("stall.events", stall_n - n0, 1);
    wave(7, 13);
    chk("stall.cleared", stalled, 0);
    wave(4, 4);
    flush("recover");

    // Reset in the middle of a low phase discards the measurement in progress.
    wave(6, 6);
    wave(6, 3);
    compare("pre_rst");
    do_reset();
    check_reset_state("mid_rst");
    wave(8, 8);
    wave(8, 8);
    flush("post_rst");

    // Fastest resolvable signal: toggle every cycle.
    repeat (10) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    flush("period2");

    // Random duty and period.
    repeat (12) wave($urandom_range(1, 12), $urandom_range(1, 12));
    flush("random");

`ifdef CLOCK_MONITOR_MINMAX_EN
    // Clear mid-interval, then periods 20, 12, 30.
    wave(10, 6);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    wave(6, 6);
    wave(15, 15);
    wave(5, 5);
    flush("minmax");
    chk("minmax.min_abs", period_min, 12);
    chk("minmax.max_abs", period_max, 30);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("minmax_clr.min", period_min, 'hFFFF);
    chk("minmax_clr.max", period_max, 0);
`endif

    @(negedge clk);
    chk("meas_valid.back_to_back", consec, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
